mimo_input_assembler: RTL and testbench
=======================================

// Module: mimo_input_assembler
// PURPOSE
//  Upstream feeder for mimo_detector. Converts a word-serial sample stream (one 16-bit fixed-point value per beat)
//  into the 128-bit InData vectors the detector consumes, tags each vector channel/data (flagChannelorData).
//  Each frame is CH_BEATS channel vectors followed by data vectors until end-of-frame.
//  Double-buffered so the source keeps streaming while the detector stalls on o_in_ready.
// PARAMETERS
//  SAMP_W    16  sample width (INT_W 6 + FRAC_W 10, two's complement)
//  WPV       8   samples per output vector (4 complex = 8 real values)
//  CH_BEATS  4   channel vectors at start of each frame
// PORTS
//  clk          in   1            rising-edge clock
//  rst_n        in   1            async active-low reset
//  s_valid      in   1            input sample valid
//  s_ready      out  1            assembler can accept sample
//  s_data       in   SAMP_W       sample
//  s_sof        in   1            qualifies first sample of a frame
//  s_eof        in   1            qualifies last sample of a frame
//  m_valid      out  1            vector valid (to detector i_in_valid)
//  m_ready      in   1            detector ready (from o_in_ready)
//  m_flag       out  1            1 = channel vector, 0 = data vector
//  m_data       out  SAMP_W*WPV   vector (to detector InData)
//  frame_err    out  1            1-cycle pulse on framing error
//  frame_done   out  1            1-cycle pulse when last vector of frame is accepted downstream
// BEHAVIOUR
//  Reset: s_ready=0, m_valid=0, m_flag=0, m_data=0, frame_err=0, frame_done=0; FSM=IDLE, counters 0.
//   s_ready rises the first clk after rst_n deasserts. Reset mid-frame discards all partial and held vectors.
//  Transfers: input on s_valid&&s_ready at posedge; output on m_valid&&m_ready at posedge.
//  Packing: sample k (0..WPV-1) of a vector goes to m_data[SAMP_W*k +: SAMP_W], sample 0 in LSBs.
//  FSM: IDLE -(accepted sample with s_sof)-> CHAN; samples without s_sof in IDLE are dropped, no error.
//   CHAN: vectors flagged 1; after CH_BEATS vectors complete -> DATA.
//   DATA: vectors flagged 0; accepted sample with s_eof completes the vector -> IDLE.
//  Short vector on s_eof (word count < WPV): remaining lanes zero-filled, vector emitted.
//  Errors (frame_err pulse, next cycle):
//   s_eof while in CHAN -> partial vector dropped, FSM -> IDLE (channel vectors already emitted stand).
//   s_sof in CHAN/DATA -> partial vector dropped, sample starts new frame in CHAN, beat count cleared.
//  Buffering: assembly reg + output reg. Completed vector moves to output reg same edge it completes
//   if output reg empty or being accepted that edge; else assembly reg holds it and s_ready=0 until moved.
//  s_ready = !(assembly full) ; combinational on registered state only (no path from m_ready).
//  Latency: last sample accepted at edge N -> m_valid high after edge N (visible cycle N+1) if output free.
//  Throughput: one vector per WPV cycles sustained with m_ready=1; no bubble between vectors.
//  m_valid, m_flag, m_data held stable while m_valid && !m_ready.
//  frame_done pulses the cycle after the eof-completed vector handshakes downstream.
//  Counters: sample counter 0..WPV-1 wraps to 0 on completion; beat counter saturates at CH_BEATS.
// TESTING
//  1 Reset: rst_n=0 mid-stream -> all outputs 0 immediately; s_ready=1 one clk after release.
//  2 Nominal frame, 4*8 channel + 11*8 data samples (sample value = index), m_ready=1 -> 15 vectors,
//    first 4 m_flag=1, next 11 m_flag=0; vector0 m_data[15:0]=0, [127:112]=7; frame_done once.
//  3 Backpressure: m_ready=0 for 20 cycles mid-frame -> s_ready drops after 2nd vector completes;
//    m_data unchanged while stalled; no sample lost or duplicated after release.
//  4 Short eof: 3 data samples then s_eof -> one vector, lanes 3..7 zero, m_flag=0, FSM IDLE.
//  5 s_sof after 5 samples of a channel vector -> frame_err pulse, partial dropped, next 4 vectors flag=1.
//  6 s_eof during channel phase -> frame_err pulse, no data vectors emitted; leading non-sof samples ignored.

Source files
------------

// File: rtl/mimo_input_assembler.sv
// Packs a word-serial sample stream into WPV-lane vectors for mimo_detector, tags channel/data
// vectors per frame, and double-buffers (assembly + output register) so the source keeps streaming.
module mimo_input_assembler #(
    parameter int SAMP_W   = 16,
    parameter int WPV      = 8,
    parameter int CH_BEATS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [SAMP_W-1:0]     s_data,
    input  logic                  s_sof,
    input  logic                  s_eof,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_flag,
    output logic [SAMP_W*WPV-1:0] m_data,
    output logic                  frame_err,
    output logic                  frame_done
);

    localparam int VEC_W  = SAMP_W * WPV;
    localparam int CNT_W  = (WPV > 1) ? $clog2(WPV) : 1;
    localparam int BEAT_W = $clog2(CH_BEATS + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CHAN = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   samp_cnt_q, samp_cnt_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [VEC_W-1:0]   asm_data_q, asm_data_d;
    logic               asm_full_q, asm_full_d;
    logic               asm_flag_q, asm_flag_d;
    logic               asm_eof_q, asm_eof_d;
    logic               out_valid_q, out_valid_d;
    logic               out_flag_q, out_flag_d;
    logic               out_eof_q, out_eof_d;
    logic [VEC_W-1:0]   out_data_q, out_data_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               live_q;

    state_t             cur_state_s;
    logic [CNT_W-1:0]   idx_s;
    logic [BEAT_W-1:0]  cur_beat_s;
    logic [BEAT_W-1:0]  beat_next_s;
    logic [VEC_W-1:0]   base_s;
    logic [VEC_W-1:0]   vec_s;
    logic               accept_s;
    logic               out_free_s;
    logic               last_lane_s;
    logic               cmpl_s;
    logic               cflag_s;
    logic               ceof_s;

    // s_ready only from registered state; live_q holds it low until the first clock after reset
    assign s_ready    = live_q && !asm_full_q;
    assign accept_s   = s_valid && s_ready;
    assign out_free_s = !out_valid_q || m_ready;

    assign m_valid    = out_valid_q;
    assign m_flag     = out_flag_q;
    assign m_data     = out_data_q;
    assign frame_err  = err_q;
    assign frame_done = done_q;

    // A sample carrying sof always restarts assembly at lane 0 of a fresh channel phase
    always_comb begin
        cur_state_s = state_q;
        idx_s       = samp_cnt_q;
        cur_beat_s  = beat_cnt_q;
        base_s      = asm_data_q;
        if (s_sof) begin
            cur_state_s = ST_CHAN;
            idx_s       = {CNT_W{1'b0}};
            cur_beat_s  = {BEAT_W{1'b0}};
            base_s      = {VEC_W{1'b0}};
        end else begin
            cur_state_s = state_q;
        end
        beat_next_s = cur_beat_s + BEAT_W'(1);
        last_lane_s = (int'(idx_s) == WPV - 1);
    end

    // Lane insert: unwritten lanes stay zero because assembly is cleared at every vector start
    always_comb begin
        vec_s = base_s;
        for (int k = 0; k < WPV; k++) begin
            if (int'(idx_s) == k) begin
                vec_s[SAMP_W*k +: SAMP_W] = s_data;
            end else begin
                vec_s[SAMP_W*k +: SAMP_W] = base_s[SAMP_W*k +: SAMP_W];
            end
        end
    end

    // Framing FSM, counters and the assembly/output buffer hand-off
    always_comb begin
        state_d     = state_q;
        samp_cnt_d  = samp_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        asm_data_d  = asm_data_q;
        asm_full_d  = asm_full_q;
        asm_flag_d  = asm_flag_q;
        asm_eof_d   = asm_eof_q;
        out_valid_d = out_valid_q;
        out_flag_d  = out_flag_q;
        out_eof_d   = out_eof_q;
        out_data_d  = out_data_q;
        err_d       = 1'b0;
        done_d      = 1'b0;
        cmpl_s      = 1'b0;
        cflag_s     = 1'b0;
        ceof_s      = 1'b0;

        if (out_valid_q && m_ready) begin
            out_valid_d = 1'b0;
            done_d      = out_eof_q;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (asm_full_q && out_free_s) begin
            out_valid_d = 1'b1;
            out_flag_d  = asm_flag_q;
            out_eof_d   = asm_eof_q;
            out_data_d  = asm_data_q;
            asm_full_d  = 1'b0;
            asm_flag_d  = 1'b0;
            asm_eof_d   = 1'b0;
            asm_data_d  = {VEC_W{1'b0}};
        end else if (accept_s) begin
            if (s_sof && (state_q != ST_IDLE)) begin
                err_d = 1'b1;
            end else begin
                err_d = 1'b0;
            end
            case (cur_state_s)
                ST_CHAN: begin
                    if (s_eof) begin
                        err_d      = 1'b1;
                        state_d    = ST_IDLE;
                        samp_cnt_d = {CNT_W{1'b0}};
                        beat_cnt_d = {BEAT_W{1'b0}};
                        asm_data_d = {VEC_W{1'b0}};
                    end else if (last_lane_s) begin
                        cmpl_s  = 1'b1;
                        cflag_s = 1'b1;
                        if (int'(beat_next_s) >= CH_BEATS) begin
                            state_d    = ST_DATA;
                            beat_cnt_d = BEAT_W'(CH_BEATS);
                        end else begin
                            state_d    = ST_CHAN;
                            beat_cnt_d = beat_next_s;
                        end
                    end else begin
                        state_d    = ST_CHAN;
                        beat_cnt_d = cur_beat_s;
                        samp_cnt_d = idx_s + CNT_W'(1);
                        asm_data_d = vec_s;
                    end
                end
                ST_DATA: begin
                    if (s_eof || last_lane_s) begin
                        cmpl_s = 1'b1;
                        ceof_s = s_eof;
                        if (s_eof) begin
                            state_d    = ST_IDLE;
                            beat_cnt_d = {BEAT_W{1'b0}};
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        samp_cnt_d = idx_s + CNT_W'(1);
                        asm_data_d = vec_s;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (cmpl_s) begin
                samp_cnt_d = {CNT_W{1'b0}};
                if (out_free_s) begin
                    out_valid_d = 1'b1;
                    out_flag_d  = cflag_s;
                    out_eof_d   = ceof_s;
                    out_data_d  = vec_s;
                    asm_data_d  = {VEC_W{1'b0}};
                end else begin
                    asm_full_d = 1'b1;
                    asm_flag_d = cflag_s;
                    asm_eof_d  = ceof_s;
                    asm_data_d = vec_s;
                end
            end else begin
                asm_full_d = asm_full_q;
            end
        end else begin
            asm_full_d = asm_full_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            samp_cnt_q  <= {CNT_W{1'b0}};
            beat_cnt_q  <= {BEAT_W{1'b0}};
            asm_data_q  <= {VEC_W{1'b0}};
            asm_full_q  <= 1'b0;
            asm_flag_q  <= 1'b0;
            asm_eof_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_flag_q  <= 1'b0;
            out_eof_q   <= 1'b0;
            out_data_q  <= {VEC_W{1'b0}};
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            samp_cnt_q  <= samp_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            asm_data_q  <= asm_data_d;
            asm_full_q  <= asm_full_d;
            asm_flag_q  <= asm_flag_d;
            asm_eof_q   <= asm_eof_d;
            out_valid_q <= out_valid_d;
            out_flag_q  <= out_flag_d;
            out_eof_q   <= out_eof_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
            done_q      <= done_d;
            live_q      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mimo_input_assembler.sv
// Directed bench for mimo_input_assembler: a cycle table for framing errors, then frame-level
// sequences for nominal streaming, backpressure, short eof and reset.
module tb_mimo_input_assembler;

    localparam int SAMP_W = 16;
    localparam int WPV    = 8;
    localparam int VEC_W  = SAMP_W * WPV;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [15:0]      s_data = 16'h0000;
    logic             s_sof = 1'b0;
    logic             s_eof = 1'b0;
    logic             m_valid;
    logic             m_ready = 1'b1;
    logic             m_flag;
    logic [VEC_W-1:0] m_data;
    logic             frame_err;
    logic             frame_done;

    int n_pass  = 0;
    int n_total = 0;
    int err_cnt = 0;
    int done_cnt = 0;
    int stall_cycles = 0;
    logic [VEC_W:0] got[$];

    typedef struct {
        logic        v, sof, eof;
        logic [15:0] d;
        logic        mr;
        logic        e_srdy, e_mv, e_flag, e_err;
        logic [15:0] e_l0, e_l7;
    } rec_t;
    rec_t tbl[$];

    mimo_input_assembler #(.SAMP_W(16), .WPV(8), .CH_BEATS(4)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_sof(s_sof), .s_eof(s_eof), .m_valid(m_valid), .m_ready(m_ready), .m_flag(m_flag),
        .m_data(m_data), .frame_err(frame_err), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Downstream monitor: record every handshaken vector and count status pulses
    always @(posedge clk) begin
        if (rst_n) begin
            if (m_valid && m_ready) got.push_back({m_flag, m_data});
            if (frame_err) err_cnt++;
            if (frame_done) done_cnt++;
        end
    end

    task automatic chk(input string nm, input logic [VEC_W:0] act, input logic [VEC_W:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [VEC_W-1:0] mk_vec(input int base, input int n);
        logic [VEC_W-1:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v[SAMP_W*k +: SAMP_W] = 16'(base + k);
        return v;
    endfunction

    function automatic rec_t row(input logic v, sof, eof, input logic [15:0] d, input logic mr,
                                 input logic e_mv, e_err, input logic [15:0] e_l0, e_l7);
        rec_t r;
        r.v = v; r.sof = sof; r.eof = eof; r.d = d; r.mr = mr;
        r.e_srdy = 1'b1; r.e_mv = e_mv; r.e_flag = 1'b1; r.e_err = e_err;
        r.e_l0 = e_l0; r.e_l7 = e_l7;
        return r;
    endfunction

    task automatic send(input logic [15:0] d, input logic sof, input logic eof);
        logic acc;
        s_valid = 1'b1; s_data = d; s_sof = sof; s_eof = eof;
        acc = 1'b0;
        for (int n = 0; n < 200 && !acc; n++) begin
            acc = s_ready;
            if (!acc) stall_cycles++;
            @(posedge clk); #1;
        end
        if (!acc) chk("accept_timeout", {128'd0, acc}, {128'd0, 1'b1});
    endtask

    task automatic send_frame(input int base, input int n);
        for (int i = 0; i < n; i++) send(16'(base + i), i == 0, i == n - 1);
        s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0;
    endtask

    task automatic wait_vecs(input int n);
        for (int c = 0; c < 300 && got.size() < n; c++) begin @(posedge clk); #1; end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic chk_frame(input string nm, input int base, input int n);
        int nv;
        nv = (n + WPV - 1) / WPV;
        chk({nm, "_count"}, 129'(got.size()), 129'(nv));
        for (int v = 0; v < nv && v < got.size(); v++)
            chk($sformatf("%s_vec%0d", nm, v), got[v],
                {v < 4, mk_vec(base + v * WPV, (n - v * WPV < WPV) ? n - v * WPV : WPV)});
    endtask

    initial begin
        int e0, d0;
        logic have, saw;
        logic [VEC_W:0] cap;
        int viol;

        // Row table: eof inside channel phase, then sof abort inside a channel vector
        tbl.push_back(row(1, 0, 0, 16'h0011, 1, 0, 0, 16'h0, 16'h0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(row(1, i == 0, 0, 16'(16'h0100 + i), 1, i == 7, 0, 16'h0100, 16'h0107));
        tbl.push_back(row(1, 0, 1, 16'h0200, 1, 0, 1, 16'h0, 16'h0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(row(1, i == 0, 0, 16'(16'h0300 + i), 1, 0, 0, 16'h0, 16'h0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(row(1, i == 0, 0, 16'(16'h0400 + i), i != 7, i == 7, i == 0,
                              16'h0400, 16'h0407));

        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("rst_sready_low", {128'd0, s_ready}, 129'd0);
        @(posedge clk); #1;
        chk("rst_sready_rise", {128'd0, s_ready}, 129'd1);

        foreach (tbl[i]) begin
            s_valid = tbl[i].v; s_sof = tbl[i].sof; s_eof = tbl[i].eof;
            s_data = tbl[i].d; m_ready = tbl[i].mr;
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_sready", i), {128'd0, s_ready}, {128'd0, tbl[i].e_srdy});
            chk($sformatf("tbl%0d_mvalid", i), {128'd0, m_valid}, {128'd0, tbl[i].e_mv});
            chk($sformatf("tbl%0d_err", i), {128'd0, frame_err}, {128'd0, tbl[i].e_err});
            if (tbl[i].e_mv) begin
                chk($sformatf("tbl%0d_flag", i), {128'd0, m_flag}, {128'd0, tbl[i].e_flag});
                chk($sformatf("tbl%0d_lanes", i), {97'd0, m_data[127:112], m_data[15:0]},
                    {97'd0, tbl[i].e_l7, tbl[i].e_l0});
            end
        end
        chk("tbl_err_pulses", 129'(err_cnt), 129'd2);
        chk("tbl_no_data_vec", 129'(got.size()), 129'd1);

        // Reset mid-stream while a vector is held on the output
        s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_outputs", {m_valid, m_flag, frame_err, frame_done, s_ready, 124'd0}, 129'd0);
        chk("rst_mdata", {1'b0, m_data}, 129'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst2_sready_rise", {128'd0, s_ready}, 129'd1);

        // Nominal frame, sample value = index
        got.delete(); m_ready = 1'b1; e0 = err_cnt; d0 = done_cnt; stall_cycles = 0;
        for (int i = 0; i < 120; i++) send(16'(i), i == 0, i == 119);
        chk("nom_latency", {m_valid, m_data}, {1'b1, mk_vec(112, 8)});
        s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0;
        wait_vecs(15);
        chk_frame("nom", 0, 120);
        chk("nom_no_stall", 129'(stall_cycles), 129'd0);
        chk("nom_done", 129'(done_cnt - d0), 129'd1);
        chk("nom_err", 129'(err_cnt - e0), 129'd0);

        // Backpressure: m_ready low for 20 cycles after the 5th vector
        got.delete(); e0 = err_cnt; d0 = done_cnt;
        have = 1'b0; saw = 1'b0; viol = 0; cap = '0;
        fork
            send_frame(1000, 120);
            begin
                for (int c = 0; c < 300 && got.size() < 5; c++) begin @(posedge clk); #1; end
                m_ready = 1'b0;
                for (int c = 0; c < 20; c++) begin
                    @(posedge clk); #1;
                    if (have && (!m_valid || {m_flag, m_data} !== cap)) viol++;
                    if (!have && m_valid) begin have = 1'b1; cap = {m_flag, m_data}; end
                    if (!s_ready) saw = 1'b1;
                end
                chk("bp_sready_low", {127'd0, saw, s_ready}, {127'd0, 1'b1, 1'b0});
                chk("bp_held", {96'd0, have, 32'(viol)}, {96'd0, 1'b1, 32'd0});
                m_ready = 1'b1;
            end
        join
        wait_vecs(15);
        chk_frame("bp", 1000, 120);
        chk("bp_done", 129'(done_cnt - d0), 129'd1);

        // Short eof: 3 data samples close the frame with a zero-filled vector
        got.delete(); e0 = err_cnt; d0 = done_cnt;
        send_frame(16'h2000, 35);
        wait_vecs(5);
        chk_frame("short", 16'h2000, 35);
        chk("short_done", 129'(done_cnt - d0), 129'd1);
        send(16'h7777, 1'b0, 1'b0);
        s_valid = 1'b0;
        repeat (12) begin @(posedge clk); #1; end
        chk("short_idle_drop", 129'(got.size()), 129'd5);
        chk("short_err", 129'(err_cnt - e0), 129'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
